// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg
//   Shared types and helpers for the instruction fetch queue.
//   fetch_entry_t : one buffered cache response {pc, inst} at the default width
//   ptr_width()   : bit width of a head/tail pointer for a given depth
package inst_fetch_queue_pkg;

   localparam int FETCH_PC_WIDTH   = 32;
   localparam int FETCH_DATA_WIDTH = 32;

   typedef struct packed {
      logic [FETCH_PC_WIDTH-1:0]   pc;
      logic [FETCH_DATA_WIDTH-1:0] inst;
   } fetch_entry_t;

   // Pointers wrap modulo depth by natural overflow, so depth must be a power of two.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   In-order buffer between the instruction cache and decode.
//   Ports:
//     clk, resetn           clock, synchronous active-low reset
//     flush                 drop all entries (redirect / exception)
//     enq_valid/pc/inst     cache response; accepted when enq_ready
//     enq_ready             queue not full
//     almost_full           count >= DEPTH-1, used as the cache stall
//     deq_valid/pc/inst     head entry to decode
//     deq_ready             decode consumes the head this cycle
//     count                 current occupancy
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   flush,
   input  logic                   enq_valid,
   input  logic [31:0]            enq_pc,
   input  logic [DATA_WIDTH-1:0]  enq_inst,
   output logic                   enq_ready,
   output logic                   almost_full,
   output logic                   deq_valid,
   output logic [31:0]            deq_pc,
   output logic [DATA_WIDTH-1:0]  deq_inst,
   input  logic                   deq_ready,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - 1);

   // Same layout as fetch_entry_t, widened to the instance's DATA_WIDTH.
   typedef struct packed {
      logic [31:0]           pc;
      logic [DATA_WIDTH-1:0] inst;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            enq_fire;
   logic            deq_fire;

   // Handshake outputs come from the registered count only, so there is no
   // combinational path from enq_valid/deq_ready back to the ready/valid flags.
   assign enq_ready   = (count_q != FULL_CNT);
   assign deq_valid   = (count_q != '0);
   assign almost_full = (count_q >= AF_CNT);
   assign count       = count_q;
   assign deq_pc      = mem_q[head_q].pc;
   assign deq_inst    = mem_q[head_q].inst;

   always_comb begin
      enq_fire = enq_valid && enq_ready;
      deq_fire = deq_valid && deq_ready;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq_fire) tail_d = tail_q + PW'(1);
         if (deq_fire) head_d = head_q + PW'(1);
         case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is never reset; a stale slot is only visible while deq_valid=0.
   always_ff @(posedge clk) begin
      if (enq_fire && !flush) begin
         mem_q[tail_q].pc   <= enq_pc;
         mem_q[tail_q].inst <= enq_inst;
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        enq_valid;
   logic [31:0] enq_pc;
   logic [31:0] enq_inst;
   logic        enq_ready;
   logic        almost_full;
   logic        deq_valid;
   logic [31:0] deq_pc;
   logic [31:0] deq_inst;
   logic        deq_ready;
   logic [3:0]  count;

   int errors = 0;
   int checks = 0;

   inst_fetch_queue #(.DEPTH(8), .DATA_WIDTH(32)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .flush       (flush),
      .enq_valid   (enq_valid),
      .enq_pc      (enq_pc),
      .enq_inst    (enq_inst),
      .enq_ready   (enq_ready),
      .almost_full (almost_full),
      .deq_valid   (deq_valid),
      .deq_pc      (deq_pc),
      .deq_inst    (deq_inst),
      .deq_ready   (deq_ready),
      .count       (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return ~pc ^ 32'h5A5A_0000;
   endfunction

   task automatic push(input logic [31:0] pc);
      enq_valid = 1'b1;
      enq_pc    = pc;
      enq_inst  = inst_of(pc);
      tick();
      enq_valid = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
      enq_pc = '0; enq_inst = '0;
      tick(); tick();
      resetn = 1'b1;
      tick();

      // reset / idle
      chk("rst_deq_valid",   32'(deq_valid),   32'd0);
      chk("rst_enq_ready",   32'(enq_ready),   32'd1);
      chk("rst_count",       32'(count),       32'd0);
      chk("rst_almost_full", 32'(almost_full), 32'd0);

      // three back-to-back enqueues, no bypass: first visible after one cycle
      push(32'hBFC0_0000);
      chk("enq1_count",  32'(count),     32'd1);
      chk("enq1_valid",  32'(deq_valid), 32'd1);
      chk("enq1_head",   deq_pc,         32'hBFC0_0000);
      push(32'hBFC0_0004);
      push(32'hBFC0_0008);
      chk("enq3_count",  32'(count), 32'd3);
      deq_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("drain_pc",   deq_pc,   32'hBFC0_0000 + 32'(4 * i));
         chk("drain_inst", deq_inst, inst_of(32'hBFC0_0000 + 32'(4 * i)));
         tick();
         chk("drain_count", 32'(count), 32'(2 - i));
      end
      chk("drain_empty", 32'(deq_valid), 32'd0);
      // deq_ready while empty is ignored
      tick();
      chk("empty_deq_count", 32'(count), 32'd0);
      deq_ready = 1'b0;

      // fill toward full
      for (int i = 0; i < 6; i++) push(32'h0000_1000 + 32'(4 * i));
      chk("cnt6_almost_full", 32'(almost_full), 32'd0);
      push(32'h0000_1018);
      chk("cnt7_count",       32'(count),       32'd7);
      chk("cnt7_almost_full", 32'(almost_full), 32'd1);
      chk("cnt7_enq_ready",   32'(enq_ready),   32'd1);
      push(32'h0000_101C);
      chk("full_count",     32'(count),     32'd8);
      chk("full_enq_ready", 32'(enq_ready), 32'd0);
      // enqueue at full is dropped
      push(32'hDEAD_BEEF);
      chk("full_drop_count", 32'(count), 32'd8);
      chk("full_drop_head",  deq_pc,     32'h0000_1000);
      // at full, simultaneous deq still cannot make room for the enqueue
      deq_ready = 1'b1;
      push(32'hDEAD_BEE0);
      chk("full_enqdeq_count", 32'(count), 32'd7);
      chk("full_enqdeq_head",  deq_pc,     32'h0000_1004);
      for (int i = 1; i < 8; i++) begin
         chk("full_drain_pc", deq_pc, 32'h0000_1000 + 32'(4 * i));
         tick();
      end
      chk("full_drain_count", 32'(count), 32'd0);
      deq_ready = 1'b0;

      // sustained enq+deq at count=4 across pointer wrap
      for (int i = 0; i < 4; i++) push(32'h0000_2000 + 32'(4 * i));
      chk("steady_pre_count", 32'(count), 32'd4);
      deq_ready = 1'b1;
      enq_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         enq_pc   = 32'h0000_2000 + 32'(4 * (k + 4));
         enq_inst = inst_of(enq_pc);
         chk("steady_pc", deq_pc, 32'h0000_2000 + 32'(4 * k));
         tick();
         chk("steady_count", 32'(count), 32'd4);
      end
      enq_valid = 1'b0;
      for (int k = 20; k < 24; k++) begin
         chk("steady_tail_pc",   deq_pc,   32'h0000_2000 + 32'(4 * k));
         chk("steady_tail_inst", deq_inst, inst_of(32'h0000_2000 + 32'(4 * k)));
         tick();
      end
      chk("steady_empty", 32'(deq_valid), 32'd0);
      deq_ready = 1'b0;

      // flush wins over same-cycle enq and deq
      for (int i = 0; i < 5; i++) push(32'h0000_3000 + 32'(4 * i));
      chk("pre_flush_count", 32'(count), 32'd5);
      flush = 1'b1; deq_ready = 1'b1;
      push(32'hDEAD_0000);
      flush = 1'b0; deq_ready = 1'b0;
      chk("flush_count",       32'(count),       32'd0);
      chk("flush_deq_valid",   32'(deq_valid),   32'd0);
      chk("flush_almost_full", 32'(almost_full), 32'd0);
      chk("flush_enq_ready",   32'(enq_ready),   32'd1);
      push(32'h0000_4000);
      chk("post_flush_count", 32'(count), 32'd1);
      chk("post_flush_head",  deq_pc,     32'h0000_4000);
      chk("post_flush_inst",  deq_inst,   inst_of(32'h0000_4000));

      // synchronous reset mid-operation
      for (int i = 1; i < 6; i++) push(32'h0000_4000 + 32'(4 * i));
      chk("pre_rst_count", 32'(count), 32'd6);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      chk("rst6_count",     32'(count),     32'd0);
      chk("rst6_deq_valid", 32'(deq_valid), 32'd0);
      chk("rst6_enq_ready", 32'(enq_ready), 32'd1);
      push(32'h0000_5000);
      chk("post_rst_head", deq_pc, 32'h0000_5000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
